turn_sequencer: RTL and testbench

- Two-player turn controller for the battle board; sequences each turn through target select, fire, resolve and damage.
- Shares the single attack datapath between player 0 and player 1 by strict alternation.
- Owns both players' health registers and declares the winner.
- Its state, health and target outputs feed the board display logic.

---
 rtl/turn_sequencer.sv | 176 +++++++++++++++++
 tb/tb_turn_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// Two-player turn controller: alternates the shared attack datapath between players,
// tracks both health registers, counts turns and declares the winner.
module turn_sequencer #(
  parameter int unsigned BOARD_MAX = 31,
  parameter int unsigned HP_INIT   = 100,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       start_i,
  input  logic       confirm_i,
  input  logic [4:0] x_i,
  input  logic [4:0] y_i,
  input  logic       atk_done_i,
  input  logic       atk_hit_i,
  input  logic [7:0] atk_damage_i,
  output logic       atk_go_o,
  output logic       atk_player_o,
  output logic [4:0] atk_x_o,
  output logic [4:0] atk_y_o,
  output logic       active_player_o,
  output logic [2:0] state_o,
  output logic [7:0] hp0_o,
  output logic [7:0] hp1_o,
  output logic [1:0] winner_o,
  output logic [7:0] turn_count_o,
  output logic       timeout_o
);

  localparam int unsigned CntW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [4:0] BoardMax     = 5'(BOARD_MAX);
  localparam logic [7:0] HpInit       = 8'(HP_INIT);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSelect = 3'd1,
    StFire   = 3'd2,
    StWait   = 3'd3,
    StApply  = 3'd4,
    StSwap   = 3'd5,
    StOver   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic              active_q, active_d;
  logic [7:0]        hp0_q, hp0_d, hp1_q, hp1_d;
  logic [1:0]        winner_q, winner_d;
  logic [7:0]        turn_q, turn_d;
  logic              timeout_q, timeout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        ax_q, ax_d, ay_q, ay_d;
  logic              hit_q, hit_d;
  logic [7:0]        dmg_q, dmg_d;
  logic [7:0]        opp_hp, opp_hp_sub;

  // Opponent of the active player is the one being attacked.
  assign opp_hp     = active_q ? hp0_q : hp1_q;
  assign opp_hp_sub = (opp_hp > dmg_q) ? (opp_hp - dmg_q) : 8'd0;

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    hp0_d     = hp0_q;
    hp1_d     = hp1_q;
    winner_d  = winner_q;
    turn_d    = turn_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    hit_d     = hit_q;
    dmg_d     = dmg_q;
    case (state_q)
      StIdle, StOver: begin
        if (start_i) begin
          hp0_d     = HpInit;
          hp1_d     = HpInit;
          winner_d  = 2'b00;
          turn_d    = 8'd0;
          timeout_d = 1'b0;
          active_d  = 1'b0;
          state_d   = StSelect;
        end
      end
      StSelect: begin
        if (confirm_i) begin
          ax_d    = (x_i > BoardMax) ? BoardMax : x_i;
          ay_d    = (y_i > BoardMax) ? BoardMax : y_i;
          state_d = StFire;
        end
      end
      StFire: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A result in the expiring cycle wins over the timeout.
        if (atk_done_i) begin
          hit_d   = atk_hit_i;
          dmg_d   = atk_damage_i;
          state_d = StApply;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          hit_d     = 1'b0;
          state_d   = StApply;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StApply: begin
        if (hit_q) begin
          if (active_q) hp0_d = opp_hp_sub;
          else          hp1_d = opp_hp_sub;
        end
        state_d = StSwap;
      end
      StSwap: begin
        turn_d = (turn_q == 8'hFF) ? turn_q : turn_q + 8'd1;
        if (opp_hp == 8'd0) begin
          winner_d = active_q ? 2'b10 : 2'b01;
          state_d  = StOver;
        end else begin
          active_d = ~active_q;
          state_d  = StSelect;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      active_q  <= 1'b0;
      hp0_q     <= HpInit;
      hp1_q     <= HpInit;
      winner_q  <= 2'b00;
      turn_q    <= 8'd0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      ax_q      <= 5'd0;
      ay_q      <= 5'd0;
      hit_q     <= 1'b0;
      dmg_q     <= 8'd0;
    end else if (en_i) begin
      state_q   <= state_d;
      active_q  <= active_d;
      hp0_q     <= hp0_d;
      hp1_q     <= hp1_d;
      winner_q  <= winner_d;
      turn_q    <= turn_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      hit_q     <= hit_d;
      dmg_q     <= dmg_d;
    end
  end

  // Gated by en so a stalled FIRE cycle does not issue repeated requests.
  assign atk_go_o        = en_i && (state_q == StFire);
  assign atk_player_o    = active_q;
  assign atk_x_o         = ax_q;
  assign atk_y_o         = ay_q;
  assign active_player_o = active_q;
  assign state_o         = state_q;
  assign hp0_o           = hp0_q;
  assign hp1_o           = hp1_q;
  assign winner_o        = winner_q;
  assign turn_count_o    = turn_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: directed turns push expected attack requests and
// end-of-turn results; a negedge monitor pops and compares them as the DUT presents them.
module tb_turn_sequencer;

  localparam int unsigned BoardMax = 20;
  localparam int unsigned HpInit   = 100;
  localparam int unsigned Timeout  = 8;

  localparam logic [2:0] SIdle = 3'd0, SSel = 3'd1, SFire = 3'd2, SWait = 3'd3,
                         SSwap = 3'd5, SOver = 3'd6;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, start = 1'b0, confirm = 1'b0;
  logic [4:0] x = '0, y = '0;
  logic       done = 1'b0, hit = 1'b0;
  logic [7:0] dmg = '0;

  logic       atk_go, atk_player, active_player, timeout;
  logic [4:0] atk_x, atk_y;
  logic [2:0] state;
  logic [7:0] hp0, hp1, turn_count;
  logic [1:0] winner;

  turn_sequencer #(
    .BOARD_MAX (BoardMax),
    .HP_INIT   (HpInit),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .en_i            (en),
    .start_i         (start),
    .confirm_i       (confirm),
    .x_i             (x),
    .y_i             (y),
    .atk_done_i      (done),
    .atk_hit_i       (hit),
    .atk_damage_i    (dmg),
    .atk_go_o        (atk_go),
    .atk_player_o    (atk_player),
    .atk_x_o         (atk_x),
    .atk_y_o         (atk_y),
    .active_player_o (active_player),
    .state_o         (state),
    .hp0_o           (hp0),
    .hp1_o           (hp1),
    .winner_o        (winner),
    .turn_count_o    (turn_count),
    .timeout_o       (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       player;
    logic [4:0] ax;
    logic [4:0] ay;
  } atk_t;

  typedef struct {
    logic [7:0] hp0;
    logic [7:0] hp1;
    logic       active;
    logic [7:0] turns;
    logic [1:0] winner;
    logic       to;
    logic [2:0] st;
  } res_t;

  atk_t atk_q[$];
  res_t res_q[$];
  atk_t ma;
  res_t mr;
  logic [2:0] prev_st = 3'd0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_st = 3'd0;
    end else begin
      if (atk_go) begin
        if (atk_q.size() == 0) begin
          chk("unexpected_atk_go", 32'd1, 32'd0);
        end else begin
          ma = atk_q.pop_front();
          chk("atk_player", atk_player, ma.player);
          chk("atk_x", atk_x, ma.ax);
          chk("atk_y", atk_y, ma.ay);
        end
      end
      if (prev_st == SSwap && state != SSwap) begin
        if (res_q.size() == 0) begin
          chk("unexpected_turn_end", 32'd1, 32'd0);
        end else begin
          mr = res_q.pop_front();
          chk("res_hp0", hp0, mr.hp0);
          chk("res_hp1", hp1, mr.hp1);
          chk("res_active", active_player, mr.active);
          chk("res_turns", turn_count, mr.turns);
          chk("res_winner", winner, mr.winner);
          chk("res_timeout", timeout, mr.to);
          chk("res_state", state, mr.st);
        end
      end
      prev_st = state;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input logic [2:0] a, input logic [2:0] b, input int budget,
                          input string name);
    int n = 0;
    while (state !== a && state !== b && n < budget) begin
      tick();
      n++;
    end
    chk(name, (state === a || state === b) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // dly < 0: never answer (timeout). gap: stall en for 5 cycles mid-WAIT and
  // pulse a stray confirm while waiting.
  task automatic play_turn(input logic [4:0] xi, input logic [4:0] yi, input logic hi,
                           input logic [7:0] di, input int dly, input bit gap,
                           input logic [4:0] ex, input logic [4:0] ey, input logic ep,
                           input logic [7:0] e0, input logic [7:0] e1, input logic ea,
                           input logic [7:0] et, input logic [1:0] ew, input logic eto,
                           input logic [2:0] est);
    atk_q.push_back('{player: ep, ax: ex, ay: ey});
    res_q.push_back('{hp0: e0, hp1: e1, active: ea, turns: et, winner: ew, to: eto, st: est});
    x = xi; y = yi; confirm = 1'b1;
    tick();
    confirm = 1'b0; x = 5'd13; y = 5'd14;
    chk("fire_state", state, SFire);
    chk("atk_go_latency", atk_go, 1'b1);
    tick();
    chk("atk_go_one_cycle", atk_go, 1'b0);
    if (dly < 0) begin
      wait_for(SSel, SOver, 40, "timeout_turn_end");
      return;
    end
    for (int i = 0; i < dly; i++) begin
      if (gap && i == 3) begin
        en = 1'b0;
        repeat (5) begin
          tick();
          chk("en_freeze_state", state, SWait);
        end
        en = 1'b1;
      end
      confirm = gap && (i == 4);
      tick();
      confirm = 1'b0;
    end
    done = 1'b1; hit = hi; dmg = di;
    tick();
    done = 1'b0; hit = 1'b0; dmg = 8'd0;
    tick();
    chk("swap_state", state, SSwap);
    chk("swap_hp0", hp0, e0);
    chk("swap_hp1", hp1, e1);
    wait_for(SSel, SOver, 10, "turn_end");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_state", state, SIdle);
    chk("rst_hp0", hp0, 8'd100);
    chk("rst_hp1", hp1, 8'd100);
    chk("rst_winner", winner, 2'b00);
    chk("rst_turns", turn_count, 8'd0);
    chk("rst_atk_go", atk_go, 1'b0);
    chk("rst_atk_x", atk_x, 5'd0);
    chk("rst_atk_y", atk_y, 5'd0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_active", active_player, 1'b0);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_select", state, SSel);

    play_turn(5'd5, 5'd7, 1'b1, 8'd30, 2, 1'b0, 5'd5, 5'd7, 1'b0,
              8'd100, 8'd70, 1'b1, 8'd1, 2'b00, 1'b0, SSel);
    done = 1'b1; hit = 1'b1; dmg = 8'd50;
    tick();
    done = 1'b0; hit = 1'b0; dmg = 8'd0;
    chk("stray_done_state", state, SSel);
    play_turn(5'd31, 5'd31, 1'b0, 8'd99, 0, 1'b0, 5'd20, 5'd20, 1'b1,
              8'd100, 8'd70, 1'b0, 8'd2, 2'b00, 1'b0, SSel);
    play_turn(5'd1, 5'd2, 1'b1, 8'd0, 7, 1'b1, 5'd1, 5'd2, 1'b0,
              8'd100, 8'd70, 1'b1, 8'd3, 2'b00, 1'b0, SSel);
    chk("atk_x_hold", atk_x, 5'd1);
    play_turn(5'd0, 5'd31, 1'b1, 8'd200, 1, 1'b0, 5'd0, 5'd20, 1'b1,
              8'd0, 8'd70, 1'b1, 8'd4, 2'b10, 1'b0, SOver);

    x = 5'd3; y = 5'd3; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    chk("over_hold_state", state, SOver);
    chk("over_hold_atk_x", atk_x, 5'd0);
    chk("over_hold_hp0", hp0, 8'd0);
    chk("over_hold_winner", winner, 2'b10);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_state", state, SSel);
    chk("restart_hp0", hp0, 8'd100);
    chk("restart_hp1", hp1, 8'd100);
    chk("restart_winner", winner, 2'b00);
    chk("restart_turns", turn_count, 8'd0);
    chk("restart_active", active_player, 1'b0);

    play_turn(5'd9, 5'd9, 1'b0, 8'd0, -1, 1'b0, 5'd9, 5'd9, 1'b0,
              8'd100, 8'd100, 1'b1, 8'd1, 2'b00, 1'b1, SSel);
    play_turn(5'd20, 5'd21, 1'b1, 8'd60, 3, 1'b0, 5'd20, 5'd20, 1'b1,
              8'd40, 8'd100, 1'b0, 8'd2, 2'b00, 1'b1, SSel);
    play_turn(5'd21, 5'd0, 1'b1, 8'd255, 0, 1'b0, 5'd20, 5'd0, 1'b0,
              8'd40, 8'd0, 1'b0, 8'd3, 2'b01, 1'b1, SOver);

    // Abort a turn mid-WAIT with an asynchronous reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    atk_q.push_back('{player: 1'b0, ax: 5'd4, ay: 5'd4});
    x = 5'd4; y = 5'd4; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick();
    tick();
    chk("pre_abort_wait", state, SWait);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", state, SIdle);
    chk("abort_hp0", hp0, 8'd100);
    chk("abort_hp1", hp1, 8'd100);
    chk("abort_atk_x", atk_x, 5'd0);
    chk("abort_atk_y", atk_y, 5'd0);
    chk("abort_timeout", timeout, 1'b0);
    chk("abort_atk_go", atk_go, 1'b0);
    #8;
    rst_n = 1'b1;
    tick();
    done = 1'b1; hit = 1'b1; dmg = 8'd50;
    tick();
    done = 1'b0; hit = 1'b0; dmg = 8'd0;
    chk("late_done_state", state, SIdle);
    chk("late_done_hp1", hp1, 8'd100);

    tick();
    chk("atk_queue_drained", atk_q.size(), 0);
    chk("res_queue_drained", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
